pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives hold (stall) and clear (flush) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits.
- Runs a post-reset flush sequence.
- Inserts a bubble into MEM/WB while MEM is stalled, so reg_write never fires twice for the same instruction.

---
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: INIT flush, memory wait, branch redirect, load-use bubble.
// Stall/flush outputs are combinational; define PIPE_PERF_CNT_EN to add perf_mem_stall/perf_lu_stall/perf_br_flush.
module pipe_hazard_ctrl #(
  parameter int INIT_FLUSH_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int REG_ADDR_WIDTH    = 5
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH         = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id,
  input  logic                      rs1_used_id,
  input  logic                      rs2_used_id,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex,
  input  logic                      mem_read_ex,
  input  logic                      branch_taken_ex,
  input  logic                      dmem_req_mem,
  input  logic                      dmem_ready,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      stall_ex,
  output logic                      stall_mem,
  output logic                      flush_id,
  output logic                      flush_ex,
  output logic                      flush_mem,
  output logic                      flush_wb,
  output logic [1:0]                ctrl_state,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]      perf_mem_stall,
  output logic [CNT_WIDTH-1:0]      perf_lu_stall,
  output logic [CNT_WIDTH-1:0]      perf_br_flush,
`endif
  output logic                      mem_timeout
);

  localparam int IW = (INIT_FLUSH_CYCLES > 1) ? $clog2(INIT_FLUSH_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2} state_t;

  state_t          state;
  logic [IW-1:0]   init_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            mw, lu, in_init, mw_act, br_act, lu_act;

  assign mw = dmem_req_mem & ~dmem_ready;
  assign lu = mem_read_ex & (rd_addr_ex != '0) &
              ((rs1_used_id & (rs1_addr_id == rd_addr_ex)) |
               (rs2_used_id & (rs2_addr_id == rd_addr_ex)));

  // Priority chain: INIT > memory wait > branch redirect > load-use.
  assign in_init = (state == INIT);
  assign mw_act  = ~in_init & mw;
  assign br_act  = ~in_init & ~mw & branch_taken_ex;
  assign lu_act  = ~in_init & ~mw & ~branch_taken_ex & lu;

  assign stall_if   = in_init | mw_act | lu_act;
  assign stall_id   = mw_act | lu_act;
  assign stall_ex   = mw_act;
  assign stall_mem  = mw_act;
  assign flush_id   = in_init | br_act;
  assign flush_ex   = in_init | br_act | lu_act;
  assign flush_mem  = in_init;
  assign flush_wb   = in_init | mw_act;
  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INIT;
      init_cnt    <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == IW'(INIT_FLUSH_CYCLES - 1))
            state <= RUN;
        end
        RUN: begin
          wait_cnt <= '0;
          if (mw)
            state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mw) begin
            if (wait_cnt != WW'(TIMEOUT_CYCLES))
              wait_cnt <= wait_cnt + 1'b1;
            // The first wait cycle is spent in RUN, so the flag lands after TIMEOUT_CYCLES stalled cycles.
            if (wait_cnt >= WW'(TIMEOUT_CYCLES - 2))
              mem_timeout <= 1'b1;
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_mem_stall <= '0;
      perf_lu_stall  <= '0;
      perf_br_flush  <= '0;
    end else begin
      if (mw_act) perf_mem_stall <= perf_mem_stall + 1'b1;
      if (lu_act) perf_lu_stall  <= perf_lu_stall + 1'b1;
      if (br_act) perf_br_flush  <= perf_br_flush + 1'b1;
    end
  end
`endif

endmodule
